// File: rtl/cruise_pkg.sv
// Shared types and default bounds for the cruise-control sequencer.
package cruise_pkg;

    localparam int unsigned SPEED_W_DEF   = 8;
    localparam int unsigned MIN_SPEED_DEF = 45;
    localparam int unsigned MAX_SPEED_DEF = 200;
    localparam int unsigned STEP_DEF      = 1;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CRUISE  = 3'd2,
        ST_ACCEL   = 3'd3,
        ST_COAST   = 3'd4,
        ST_SUSPEND = 3'd5
    } cruise_state_e;

    // One-hot command from the sequencer to the target register; all-zero holds.
    typedef struct packed {
        logic load;
        logic inc;
        logic dec;
        logic clear;
    } tgt_op_t;

endpackage

// File: rtl/cruise_ctrl_fsm_speed_target_reg.sv
// Held cruise-speed register with saturating load/step operations.
module speed_target_reg
    import cruise_pkg::*;
#(
    parameter int unsigned SPEED_W   = SPEED_W_DEF,
    parameter int unsigned MIN_SPEED = MIN_SPEED_DEF,
    parameter int unsigned MAX_SPEED = MAX_SPEED_DEF,
    parameter int unsigned STEP      = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  tgt_op_t            op_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic [SPEED_W-1:0] cruise_speed_o
);

    localparam logic [SPEED_W:0] MAX_W  = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [SPEED_W:0] MIN_W  = (SPEED_W+1)'(MIN_SPEED);
    localparam logic [SPEED_W:0] STEP_W = (SPEED_W+1)'(STEP);

    logic [SPEED_W-1:0] cruise_speed_q;
    logic [SPEED_W-1:0] cruise_speed_d;
    logic [SPEED_W:0]   cur_w;
    logic [SPEED_W:0]   spd_w;
    logic [SPEED_W:0]   sum_w;

    // One extra bit so the increment cannot wrap before saturation.
    assign cur_w = {1'b0, cruise_speed_q};
    assign spd_w = {1'b0, speed_i};
    assign sum_w = cur_w + STEP_W;

    always_comb begin
        cruise_speed_d = cruise_speed_q;
        if (op_i.clear) begin
            cruise_speed_d = '0;
        end else if (op_i.load) begin
            cruise_speed_d = (spd_w > MAX_W) ? MAX_W[SPEED_W-1:0] : speed_i;
        end else if (op_i.inc) begin
            cruise_speed_d = (sum_w > MAX_W) ? MAX_W[SPEED_W-1:0] : sum_w[SPEED_W-1:0];
        end else if (op_i.dec) begin
            cruise_speed_d = (cur_w < MIN_W + STEP_W) ? MIN_W[SPEED_W-1:0]
                                                      : cruise_speed_q - STEP_W[SPEED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cruise_speed_q <= '0;
        end else begin
            cruise_speed_q <= cruise_speed_d;
        end
    end

    assign cruise_speed_o = cruise_speed_q;

endmodule

// File: rtl/cruise_ctrl_fsm.sv
// Cruise-control sequencer: engage/suspend/resume state and target-speed commands.
module cruise_ctrl_fsm
    import cruise_pkg::*;
#(
    parameter int unsigned SPEED_W   = SPEED_W_DEF,
    parameter int unsigned MIN_SPEED = MIN_SPEED_DEF,
    parameter int unsigned MAX_SPEED = MAX_SPEED_DEF,
    parameter int unsigned STEP      = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               on_off_i,
    input  logic               set_i,
    input  logic               accel_i,
    input  logic               coast_i,
    input  logic               resume_i,
    input  logic               cancel_i,
    input  logic               brake_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic [SPEED_W-1:0] cruise_speed_o,
    output logic               cruise_active_o,
    output logic               valid_target_o,
    output logic [2:0]         state_o
);

    cruise_state_e state_q, state_d;
    logic          active_q, active_d;
    logic          valid_q, valid_d;
    tgt_op_t       op;
    logic          stop;
    logic          set_ok;

    assign stop   = brake_i | cancel_i;
    assign set_ok = set_i && (speed_i >= SPEED_W'(MIN_SPEED));

    // Priority: on_off=0, brake, cancel, set, accel, coast, resume.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        op      = '0;
        if (!on_off_i) begin
            state_d  = ST_OFF;
            valid_d  = 1'b0;
            op.clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_OFF: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!stop && set_ok) begin
                        state_d = ST_CRUISE;
                        op.load = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                ST_CRUISE: begin
                    if (stop) begin
                        state_d = ST_SUSPEND;
                    end else if (set_i) begin
                        op.load = set_ok;
                    end else if (accel_i) begin
                        state_d = ST_ACCEL;
                    end else if (coast_i) begin
                        state_d = ST_COAST;
                    end
                end
                ST_ACCEL: begin
                    if (stop)          state_d = ST_SUSPEND;
                    else if (!accel_i) state_d = ST_CRUISE;
                    else               op.inc  = 1'b1;
                end
                ST_COAST: begin
                    if (stop)          state_d = ST_SUSPEND;
                    else if (!coast_i) state_d = ST_CRUISE;
                    else               op.dec  = 1'b1;
                end
                ST_SUSPEND: begin
                    if (stop) begin
                        state_d = ST_SUSPEND;
                    end else if (set_i) begin
                        if (set_ok) begin
                            state_d = ST_CRUISE;
                            op.load = 1'b1;
                            valid_d = 1'b1;
                        end
                    end else if (!accel_i && !coast_i && resume_i && valid_q) begin
                        state_d = ST_CRUISE;
                    end
                end
                default: begin
                    state_d  = ST_OFF;
                    valid_d  = 1'b0;
                    op.clear = 1'b1;
                end
            endcase
        end
        active_d = (state_d == ST_CRUISE) || (state_d == ST_ACCEL) || (state_d == ST_COAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    speed_target_reg #(
        .SPEED_W  (SPEED_W),
        .MIN_SPEED(MIN_SPEED),
        .MAX_SPEED(MAX_SPEED),
        .STEP     (STEP)
    ) u_target (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_i          (op),
        .speed_i       (speed_i),
        .cruise_speed_o(cruise_speed_o)
    );

    assign cruise_active_o = active_q;
    assign valid_target_o  = valid_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cruise_ctrl_fsm.sv
// Directed scoreboard bench for cruise_ctrl_fsm; each driven cycle queues its expected outputs.
module tb_cruise_ctrl_fsm;

    // Control vector bit order: {on_off, set, accel, coast, resume, cancel, brake}
    localparam logic [6:0] C_ON  = 7'b1000000;
    localparam logic [6:0] C_SET = 7'b1100000;
    localparam logic [6:0] C_ACC = 7'b1010000;
    localparam logic [6:0] C_CST = 7'b1001000;
    localparam logic [6:0] C_RES = 7'b1000100;
    localparam logic [6:0] C_CAN = 7'b1000010;
    localparam logic [6:0] C_BRK = 7'b1000001;
    localparam logic [6:0] C_OFF = 7'b0000000;

    logic       clk;
    logic       rst_n;
    logic       on_off, set, accel, coast, resume, cancel, brake;
    logic [7:0] speed;
    logic [7:0] cruise_speed;
    logic       cruise_active;
    logic       valid_target;
    logic [2:0] state;

    // Packed expectation: {state[2:0], cruise_speed[7:0], cruise_active, valid_target}
    logic [12:0] exp_q[$];
    int          id_q[$];
    int          checks;
    int          passes;
    int          step_id;

    cruise_ctrl_fsm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .on_off_i       (on_off),
        .set_i          (set),
        .accel_i        (accel),
        .coast_i        (coast),
        .resume_i       (resume),
        .cancel_i       (cancel),
        .brake_i        (brake),
        .speed_i        (speed),
        .cruise_speed_o (cruise_speed),
        .cruise_active_o(cruise_active),
        .valid_target_o (valid_target),
        .state_o        (state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Direct comparison, used where no clock edge is involved (reset checks).
    task automatic check_now(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = {state, cruise_speed, cruise_active, valid_target};
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got state=%0d speed=%0d active=%0b valid=%0b, expected state=%0d speed=%0d active=%0b valid=%0b",
                      name, got[12:10], got[9:2], got[1], got[0], exp[12:10], exp[9:2], exp[1], exp[0]);
    endtask

    // Driver: apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic drive(input logic [6:0] ctl, input logic [7:0] spd,
                         input logic [2:0] e_st, input logic [7:0] e_spd,
                         input logic e_act, input logic e_val);
        @(negedge clk);
        {on_off, set, accel, coast, resume, cancel, brake} = ctl;
        speed = spd;
        step_id++;
        exp_q.push_back({e_st, e_spd, e_act, e_val});
        id_q.push_back(step_id);
        @(posedge clk);
    endtask

    // Monitor / scoreboard: outputs are registered and meaningful every cycle.
    initial begin
        logic [12:0] got, exp;
        int          id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                id  = id_q.pop_front();
                got = {state, cruise_speed, cruise_active, valid_target};
                checks++;
                if (got === exp) passes++;
                else $display("FAIL step %0d: got state=%0d speed=%0d active=%0b valid=%0b, expected state=%0d speed=%0d active=%0b valid=%0b",
                              id, got[12:10], got[9:2], got[1], got[0], exp[12:10], exp[9:2], exp[1], exp[0]);
            end
        end
    end

    initial begin
        checks  = 0;
        passes  = 0;
        step_id = 0;
        rst_n   = 1'b0;
        {on_off, set, accel, coast, resume, cancel, brake} = C_OFF;
        speed   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_values", {3'd0, 8'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        drive(C_ON,  8'd0,   3'd1, 8'd0,   1'b0, 1'b0);  // OFF -> IDLE
        drive(C_SET, 8'd30,  3'd1, 8'd0,   1'b0, 1'b0);  // below MIN: ignored
        drive(C_SET, 8'd60,  3'd2, 8'd60,  1'b1, 1'b1);  // engage
        drive(C_ON,  8'd90,  3'd2, 8'd60,  1'b1, 1'b1);  // hold
        drive(C_SET, 8'd198, 3'd2, 8'd198, 1'b1, 1'b1);  // recapture
        drive(C_ACC, 8'd198, 3'd3, 8'd198, 1'b1, 1'b1);  // enter ACCEL, no step
        drive(C_ACC, 8'd198, 3'd3, 8'd199, 1'b1, 1'b1);
        drive(C_ACC, 8'd198, 3'd3, 8'd200, 1'b1, 1'b1);
        drive(C_ACC, 8'd198, 3'd3, 8'd200, 1'b1, 1'b1);  // saturated at MAX
        drive(C_ACC, 8'd198, 3'd3, 8'd200, 1'b1, 1'b1);
        drive(C_ON,  8'd198, 3'd2, 8'd200, 1'b1, 1'b1);  // release
        drive(C_SET, 8'd250, 3'd2, 8'd200, 1'b1, 1'b1);  // load clamps to MAX
        drive(C_SET, 8'd47,  3'd2, 8'd47,  1'b1, 1'b1);
        drive(C_CST, 8'd47,  3'd4, 8'd47,  1'b1, 1'b1);  // enter COAST, no step
        drive(C_CST, 8'd47,  3'd4, 8'd46,  1'b1, 1'b1);
        drive(C_CST, 8'd47,  3'd4, 8'd45,  1'b1, 1'b1);
        drive(C_CST, 8'd47,  3'd4, 8'd45,  1'b1, 1'b1);  // floor at MIN
        drive(C_BRK, 8'd47,  3'd5, 8'd45,  1'b0, 1'b1);  // brake -> SUSPEND
        drive(C_BRK | C_RES, 8'd47, 3'd5, 8'd45, 1'b0, 1'b1);  // resume under brake ignored
        drive(C_RES, 8'd47,  3'd2, 8'd45,  1'b1, 1'b1);  // resume
        drive(C_ACC | C_CST, 8'd47, 3'd3, 8'd45, 1'b1, 1'b1);  // accel beats coast
        drive(C_ACC | C_CST, 8'd47, 3'd3, 8'd46, 1'b1, 1'b1);
        drive(C_ON,  8'd47,  3'd2, 8'd46,  1'b1, 1'b1);
        drive(C_CAN, 8'd47,  3'd5, 8'd46,  1'b0, 1'b1);  // cancel -> SUSPEND
        drive(C_ACC, 8'd47,  3'd5, 8'd46,  1'b0, 1'b1);  // accel ignored in SUSPEND
        drive(C_SET, 8'd80,  3'd2, 8'd80,  1'b1, 1'b1);  // set from SUSPEND recaptures
        drive(C_OFF, 8'd80,  3'd0, 8'd0,   1'b0, 1'b0);  // on_off=0 clears
        drive(C_OFF | 7'b0100000, 8'd80, 3'd0, 8'd0, 1'b0, 1'b0);  // set while off ignored
        drive(C_ON,  8'd80,  3'd1, 8'd0,   1'b0, 1'b0);
        drive(C_RES, 8'd80,  3'd1, 8'd0,   1'b0, 1'b0);  // resume in IDLE ignored
        drive(C_SET, 8'd80,  3'd2, 8'd80,  1'b1, 1'b1);
        drive(C_ACC, 8'd80,  3'd3, 8'd80,  1'b1, 1'b1);
        drive(C_ACC, 8'd80,  3'd3, 8'd81,  1'b1, 1'b1);

        // Asynchronous reset between edges while in ACCEL.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_mid_accel", {3'd0, 8'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_ACC, 8'd80,  3'd1, 8'd0,   1'b0, 1'b0);  // OFF -> IDLE after reset

        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cruise_ctrl_fsm.md
Name: cruise_ctrl_fsm

Overview:
- Top-level cruise-control sequencer.
- Decides when the held cruise-speed register is loaded from measured speed, stepped up/down or held.
- Tracks engage/suspend/resume state from driver controls.
- Drives a registered target speed and active flag to the downstream speed regulator.

Parameters:
SPEED_W, 8, width of speed and cruise_speed in km/h (unsigned)
MIN_SPEED, 45, lowest speed at which cruise may engage; lower bound for cruise_speed while engaged
MAX_SPEED, 200, upper saturation bound for cruise_speed
STEP, 1, cruise_speed change per clock while ACCEL/COAST held

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
on_off  input  1  level; 1 = cruise system enabled
set  input  1  level; capture current speed and engage
accel  input  1  level; raise target while held
coast  input  1  level; lower target while held
resume  input  1  level; re-engage at stored target
cancel  input  1  level; disengage, keep stored target
brake  input  1  level; disengage, keep stored target
speed  input  SPEED_W  measured vehicle speed
cruise_speed  output  SPEED_W  held target speed
cruise_active  output  1  1 in CRUISE, ACCEL, COAST
valid_target  output  1  1 once cruise_speed has been captured since last OFF
state  output  3  OFF=0, IDLE=1, CRUISE=2, ACCEL=3, COAST=4, SUSPEND=5

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset mid-operation forces all outputs to reset values immediately, regardless of state.
- Reset values: state=OFF, cruise_speed=0, valid_target=0, cruise_active=0.
- All outputs registered. Input sampled at edge N is reflected on outputs after edge N (latency 1).
- Global priority, highest first: on_off=0, brake, cancel, set, accel, coast, resume. Only the highest-priority active input acts.
- on_off=0 from any state:
  - next state OFF; cruise_speed=0; valid_target=0.
- OFF:
  - on_off=1 -> IDLE.
- IDLE:
  - set && speed>=MIN_SPEED -> CRUISE; cruise_speed<=min(speed,MAX_SPEED); valid_target<=1.
  - set with speed<MIN_SPEED is ignored; remain IDLE.
  - accel, coast, resume ignored.
- CRUISE:
  - brake|cancel -> SUSPEND.
  - set (speed>=MIN_SPEED) -> recapture speed; stay CRUISE.
  - accel -> ACCEL.
  - coast -> COAST.
- ACCEL:
  - Each cycle in state: cruise_speed<=min(cruise_speed+STEP, MAX_SPEED). Compute in SPEED_W+1 bits, no wrap.
  - accel=0 -> CRUISE, no step that cycle.
  - brake|cancel -> SUSPEND, no step.
- COAST:
  - Each cycle: cruise_speed<=max(cruise_speed-STEP, MIN_SPEED). Never wraps below 0.
  - coast=0 -> CRUISE.
  - brake|cancel -> SUSPEND.
- SUSPEND:
  - cruise_speed held.
  - resume && valid_target -> CRUISE.
  - set && speed>=MIN_SPEED -> CRUISE with recapture.
  - accel/coast ignored.
- accel and coast both high: accel wins (priority).
- brake held continuously: stays SUSPEND; resume while brake=1 is ignored.
- No entry is possible from SUSPEND to IDLE; only on_off=0 clears valid_target.
- Unused state encodings (6, 7) -> OFF on next edge with OFF output values.

Decomposition:
- Shared package cruise_pkg:
  - state enum/localparams OFF..SUSPEND.
  - SPEED_W default.
  - MIN_SPEED and MAX_SPEED defaults.
- One sub-module: speed_target_reg.
  - Holds cruise_speed.
  - Ops: load/inc/dec/clear with saturation bounds as parameters.
  - FSM supplies the one-hot op.
- Next-state logic stays in cruise_ctrl_fsm.

Test Plan:
- Reset then on_off=1 -> state OFF after reset, IDLE after 1 edge; cruise_speed=0, cruise_active=0.
- IDLE, speed=60, set for 1 cycle -> CRUISE, cruise_speed=60, valid_target=1. Repeat with speed=30 -> stays IDLE, cruise_speed=0.
- CRUISE at 198, accel held 5 cycles -> ACCEL, cruise_speed 199, 200, 200, 200. Release -> CRUISE at 200.
- CRUISE at 47, coast held 4 cycles -> 46, 45, 45. Then brake=1 -> SUSPEND, cruise_speed=45, cruise_active=0.
- SUSPEND, resume with brake=1 -> stays SUSPEND. Brake=0, resume=1 -> CRUISE at 45.
- CRUISE at 80, on_off=0 -> OFF, cruise_speed=0, valid_target=0. Also assert rst_n=0 mid-ACCEL between edges -> outputs reset without clock.
